// File: rtl/tdm_demux_1x4.sv
// Receiving end of the 4:1 TDM link: tracks the slot, steers each valid sample
// into one of four held channel registers, and keeps frame lock.
module tdm_demux_1x4 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   d,
  input  logic           v,
  input  logic           sync,
  output logic [4*W-1:0] q,
  output logic [3:0]     o,
  output logic [1:0]     s,
  output logic           frame,
  output logic           locked,
  output logic           err
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  state_t         state;
  logic [W-1:0]   ch [4];
  logic           frame_ok;

  function automatic logic [3:0] onehot(input logic [1:0] k);
    onehot = 4'b0001 << k;
  endfunction

  assign q = {ch[3], ch[2], ch[1], ch[0]};

  // single registered stage: sample accepted at edge N is visible right after edge N
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      s        <= 2'd0;
      o        <= 4'b0000;
      frame    <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
      frame_ok <= 1'b0;
      for (int k = 0; k < 4; k++) ch[k] <= '0;
    end else begin
      o     <= 4'b0000;
      frame <= 1'b0;
      err   <= 1'b0;
      if (v) begin
        case (state)
          HUNT: begin
            if (sync) begin
              ch[0]    <= d;
              o        <= onehot(2'd0);
              s        <= 2'd1;
              state    <= LOCK;
              locked   <= 1'b1;
              frame_ok <= 1'b1;
            end
          end
          LOCK: begin
            if (sync && (s != 2'd0)) begin
              // early marker: drop the partial frame and restart at channel 0
              err      <= 1'b1;
              ch[0]    <= d;
              o        <= onehot(2'd0);
              s        <= 2'd1;
              frame_ok <= 1'b1;
            end else if (!sync && (s == 2'd0)) begin
              err      <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
              frame_ok <= 1'b0;
            end else begin
              ch[s] <= d;
              o     <= onehot(s);
              s     <= s + 2'd1;
              if (s == 2'd0) frame_ok <= 1'b1;
              if ((s == 2'd3) && frame_ok) frame <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Scoreboard bench for tdm_demux_1x4: a frame-level reference model queues the
// expected outputs for every edge and a monitor compares them after each edge.
module tb_tdm_demux_1x4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [W-1:0]   d;
  logic           v;
  logic           sync;
  logic [4*W-1:0] q;
  logic [3:0]     o;
  logic [1:0]     s;
  logic           frame;
  logic           locked;
  logic           err;

  tdm_demux_1x4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .d(d), .v(v), .sync(sync),
    .q(q), .o(o), .s(s), .frame(frame), .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*W-1:0] q;
    logic [3:0]     o;
    logic [1:0]     s;
    logic           frame;
    logic           locked;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   started = 0;

  // reference model: channel contents, next slot, lock flag, count of in-order
  // channels gathered in the current frame
  logic [W-1:0] m_ch [4];
  int           m_slot = 0;
  bit           m_lock = 0;
  int           m_cnt  = 0;

  task automatic step(input bit r, input bit vv, input bit sy, input logic [W-1:0] dd);
    exp_t e;
    @(negedge clk);
    rst = r; v = vv; sync = sy; d = dd;
    e.o = 4'b0; e.frame = 1'b0; e.err = 1'b0;
    if (r) begin
      for (int k = 0; k < 4; k++) m_ch[k] = '0;
      m_slot = 0; m_lock = 0; m_cnt = 0;
    end else if (vv) begin
      if (!m_lock) begin
        if (sy) begin
          m_ch[0] = dd; m_slot = 1; m_lock = 1; m_cnt = 1; e.o = 4'b0001;
        end
      end else if (sy && m_slot != 0) begin
        e.err = 1'b1; m_ch[0] = dd; m_slot = 1; m_cnt = 1; e.o = 4'b0001;
      end else if (!sy && m_slot == 0) begin
        e.err = 1'b1; m_lock = 0; m_cnt = 0;
      end else begin
        m_ch[m_slot] = dd;
        e.o = 4'(1 << m_slot);
        m_cnt = (m_slot == 0) ? 1 : m_cnt + 1;
        if (m_slot == 3 && m_cnt == 4) e.frame = 1'b1;
        m_slot = (m_slot + 1) % 4;
      end
    end
    e.q = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
    e.s = 2'(m_slot);
    e.locked = m_lock;
    exp_q.push_back(e);
    started = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // monitor: the DUT presents a new output set after every clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
          checks--;
          e = exp_q.pop_front();
          chk("q", 32'(q), 32'(e.q));
          chk("o", 32'(o), 32'(e.o));
          chk("s", 32'(s), 32'(e.s));
          chk("frame", 32'(frame), 32'(e.frame));
          chk("locked", 32'(locked), 32'(e.locked));
          chk("err", 32'(err), 32'(e.err));
          chk("err_and_frame", 32'(err & frame), 32'd0);
        end
      end
    end
  end

  initial begin
    bit sy;
    rst = 1'b1; v = 1'b0; sync = 1'b0; d = '0;
    for (int k = 0; k < 4; k++) m_ch[k] = '0;
    // reset and lock-on
    step(1, 0, 0, 8'h00);
    step(1, 1, 1, 8'hEE);
    step(0, 1, 1, 8'hA1);
    step(0, 1, 0, 8'hB2);
    step(0, 1, 0, 8'hC3);
    step(0, 1, 0, 8'hD4);
    step(0, 0, 0, 8'h00);
    // HUNT discard
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) step(0, 1, i == 0, 8'(8'h20 + i));
    // gap between slots 1 and 2
    step(0, 1, 1, 8'h31);
    step(0, 1, 0, 8'h32);
    step(0, 0, 0, 8'hFF);
    step(0, 0, 1, 8'hFE);
    step(0, 1, 0, 8'h33);
    step(0, 1, 0, 8'h34);
    // early sync on slot 2
    step(0, 1, 1, 8'h41);
    step(0, 1, 0, 8'h42);
    step(0, 1, 1, 8'h55);
    step(0, 1, 0, 8'h43);
    step(0, 1, 0, 8'h44);
    step(0, 1, 0, 8'h45);
    // missing sync at slot 0, then stay in HUNT until sync
    step(0, 1, 0, 8'h66);
    step(0, 1, 0, 8'h67);
    step(0, 1, 1, 8'h70);
    // reset mid-frame after slot 1
    step(0, 1, 0, 8'h71);
    step(1, 1, 0, 8'h72);
    step(0, 1, 0, 8'h73);
    step(0, 1, 0, 8'h74);
    step(0, 1, 1, 8'h80);
    step(0, 1, 0, 8'h81);
    step(0, 1, 0, 8'h82);
    step(0, 1, 0, 8'h83);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (m_slot == 0) sy = ($urandom_range(0, 99) < 85);
      else             sy = ($urandom_range(0, 99) < 8);
      step($urandom_range(0, 99) < 1, $urandom_range(0, 3) != 0, sy, 8'($urandom));
    end
    step(0, 0, 0, 8'h00);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1x4.md
# tdm_demux_1x4

Time-division demultiplexer that is the receiving end of the 4:1 channel-select path. A single sample stream carrying four interleaved channels (slot order 0,1,2,3, repeating) arrives with a frame marker on slot 0. The block tracks the slot with a 2-bit counter and steers each sample into one of four held channel registers. It also keeps frame lock and flags framing errors. It sits downstream of the 4x1 mux and the shared serial link, and feeds per-channel logic.

## Interface
- W, default 1: data width of one channel sample.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- d  input  W  incoming sample.
- v  input  1  d is a valid sample this cycle.
- sync  input  1  frame marker; meaningful only when v=1; marks the slot-0 sample.
- q  output  4W  channel registers; channel k at q[kW+W-1:kW].
- o  output  4  registered one-hot write strobe; o[k]=1 in the cycle after channel k is written.
- s  output  2  slot the next valid sample will be written to.
- frame  output  1  one-cycle pulse: a complete, in-order frame now sits in q.
- locked  output  1  1 while in LOCK.
- err  output  1  one-cycle framing-error pulse.

## Operation
- Reset (rst=1 at a clock edge) sets q=0, o=0, s=0, frame=0, locked=0, err=0, and the state to HUNT. rst has priority over all inputs, including mid-frame.
- Cycles with v=0 change nothing: q, s and state hold; o, frame and err return to 0.
- HUNT state:
  - v=1, sync=0: the sample is discarded and s stays 0.
  - v=1, sync=1: d is written to channel 0, o=0001, s becomes 1, the state moves to LOCK, and locked=1.
- LOCK state, on v=1:
  - sync matches the slot (sync=1 with s=0, or sync=0 with s≠0): d is written to channel s, o[s]=1, and s increments modulo 4 (3 wraps to 0).
  - The write to channel 3 produces frame=1 in the next cycle, but only if that frame began with a sync'd channel-0 write in LOCK and had no error.
  - sync=1 with s≠0 (early marker): err=1 and the block resyncs. d is written to channel 0, o=0001, s becomes 1, and the state stays LOCK. The partial frame gets no frame pulse.
  - sync=0 with s=0 (missing marker): err=1, the sample is discarded, q and o are not written, s stays 0, the state moves to HUNT, and locked=0.
- Channel registers not written hold their value. q is never cleared except by reset.
- s, locked and q are plain state registers. o, frame and err are registered pulses, each lasting one cycle per event.

## Timing
- Latency is 1 cycle: a sample accepted at edge N appears on q immediately after edge N. o, frame and err are valid during that same following cycle.
- Full sample throughput: v may stay high every cycle, and a frame completes every 4 valid cycles. With v=1 continuously, frame pulses every 4th cycle.
- Gaps (v=0) may fall anywhere inside a frame and do not break lock.
- s updates on the same edge as the write, so s always shows the next target slot.
- err and frame are never 1 in the same cycle.

## Test plan
- Reset and lock-on: assert rst, then send v=1 with d=A,B,C,D and sync on A (W=8). Required: all outputs 0 after reset. Then o=0001,0010,0100,1000 on successive cycles, q={D,C,B,A}, frame=1 exactly once (cycle after D), locked=1 from the cycle after A.
- HUNT discard: send 3 samples with sync=0, then a sync'd frame. Required: q stays 0 and s=0 through the first 3; then normal fill.
- Gaps: send a frame with v=0 for 2 cycles between slots 1 and 2. Required: q and s hold across the gap, and frame fires after slot 3.
- Early sync: while locked, assert sync on slot 2 with d=0x55. Required: err=1 for 1 cycle, channel 0 becomes 0x55, s=1, no frame pulse for the aborted frame.
- Missing sync: while locked, send v=1, sync=0 at s=0. Required: err=1, q unchanged, locked=0 next cycle, HUNT until the next sync.
- Reset mid-frame: assert rst after slot 1. Required: q=0, s=0, locked=0 next cycle; the remaining samples are discarded until sync.
